// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS I CPU and its bus arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } bus_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // Size code 3 is reserved and always treated as misaligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mips_bus_lane.sv
// Little-endian byte-lane steering: store lanes/enables and load extraction/extension.
module mips_bus_lane
  import mips_pkg::*;
(
  input  access_size_t size,
  input  logic         sgn,
  input  logic [1:0]   addr_lo,
  input  logic [31:0]  wdata,
  input  logic [31:0]  readdata,
  output logic [3:0]   byteenable,
  output logic [31:0]  writedata,
  output logic [31:0]  rdata
);

  logic [31:0] shifted;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    shifted    = readdata >> {addr_lo, 3'b000};
    lane8      = shifted[7:0];
    lane16     = addr_lo[1] ? readdata[31:16] : readdata[15:0];
    byteenable = 4'b1111;
    writedata  = wdata;
    rdata      = readdata;
    case (size)
      SIZE_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        writedata  = {4{wdata[7:0]}};
        rdata      = {{24{sgn & lane8[7]}}, lane8};
      end
      SIZE_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        writedata  = {2{wdata[15:0]}};
        rdata      = {{16{sgn & lane16[15]}}, lane16};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Arbitrates fetch and load/store requests onto one Avalon-MM master port.
module mips_bus_arbiter
  import mips_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_signed,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [31:0]       address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);

  bus_state_t   state_q, state_d;
  access_size_t txn_size, lane_size;
  logic         txn_is_data, txn_signed;
  logic [1:0]   txn_addr_lo, lane_addr;
  logic         start, pick_data, sel_mis;
  logic [31:0]  sel_addr, lane_wdata, lane_rdata;
  logic [3:0]   lane_be;

  assign start     = if_req | d_req;
  assign pick_data = d_req & (DATA_FIRST | ~if_req);
  assign sel_addr  = pick_data ? d_addr : if_addr;
  assign sel_mis   = pick_data & misaligned(d_size, d_addr[1:0]);

  // The lane unit sees the live request while idle and the latched transaction afterwards.
  assign lane_size = (state_q != IDLE) ? txn_size :
                     (pick_data ? access_size_t'(d_size) : SIZE_WORD);
  assign lane_addr = (state_q != IDLE) ? txn_addr_lo :
                     (pick_data ? sel_addr[1:0] : 2'b00);

  mips_bus_lane u_lane (
    .size       (lane_size),
    .sgn        (txn_signed),
    .addr_lo    (lane_addr),
    .wdata      (d_wdata),
    .readdata   (readdata),
    .byteenable (lane_be),
    .writedata  (lane_wdata),
    .rdata      (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = sel_mis ? DONE : BUS;
      BUS:     if (!waitrequest) state_d = write ? DONE : RDATA;
      RDATA:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read        <= 1'b0;
      write       <= 1'b0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      address     <= '0;
      writedata   <= '0;
      byteenable  <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      stall_cnt   <= '0;
      txn_is_data <= 1'b0;
      txn_size    <= SIZE_WORD;
      txn_signed  <= 1'b0;
      txn_addr_lo <= 2'b00;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      if ((read | write) & waitrequest & (stall_cnt != {PERF_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      case (state_q)
        IDLE: if (start) begin
          txn_is_data <= pick_data;
          txn_size    <= lane_size;
          txn_signed  <= d_signed;
          txn_addr_lo <= lane_addr;
          if (sel_mis) begin
            d_ack <= 1'b1;
            d_err <= 1'b1;
          end else begin
            address    <= {sel_addr[31:2], 2'b00};
            byteenable <= lane_be;
            writedata  <= lane_wdata;
            read       <= ~(pick_data & d_we);
            write      <= pick_data & d_we;
          end
        end
        BUS: if (!waitrequest) begin
          read  <= 1'b0;
          write <= 1'b0;
          if (write) d_ack <= 1'b1;
        end
        // Readdata arrives with fixed latency one after acceptance.
        RDATA: begin
          if (txn_is_data) begin
            d_rdata <= lane_rdata;
            d_ack   <= 1'b1;
          end else begin
            if_rdata <= lane_rdata;
            if_ack   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Randomized bench for mips_bus_arbiter acting as CPU and Avalon slave.
module tb_mips_bus_arbiter;
  import mips_pkg::*;

  localparam bit DATA_FIRST = 1'b1;
  localparam int PERF_W     = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
  logic [31:0]       if_addr = '0, d_addr = '0, d_wdata = '0, readdata = '0;
  logic [1:0]        d_size = 2'd2;
  logic              waitrequest = 1'b0;
  logic              if_ack, d_ack, d_err, read, write;
  logic [31:0]       if_rdata, d_rdata, address, writedata;
  logic [3:0]        byteenable;
  logic [PERF_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [1:0]  size;
    bit          sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
  } txn_t;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.DATA_FIRST(DATA_FIRST), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .d_err(d_err), .stall_cnt(stall_cnt),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(bit is_data, bit we, logic [1:0] size, bit sgn,
                              logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] rdata, int waits);
    txn_t t;
    t.is_data = is_data; t.we = we; t.size = size; t.sgn = sgn;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.waits = waits;
    return t;
  endfunction

  // Reference model: derived directly from the access rules.
  function automatic bit m_mis(txn_t t);
    int a = int'(t.addr[1:0]);
    if (!t.is_data) return 0;
    if (t.size == 2'd3) return 1;
    if (t.size == 2'd1) return (a % 2) != 0;
    if (t.size == 2'd2) return a != 0;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(txn_t t);
    int a = int'(t.addr[1:0]);
    if (!t.is_data || t.size == 2'd2) return 4'hF;
    if (t.size == 2'd0) return 4'(1 << a);
    return (a >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wd(txn_t t);
    if (t.size == 2'd0) return (t.wdata & 32'hFF) * 32'h01010101;
    if (t.size == 2'd1) return (t.wdata & 32'hFFFF) * 32'h00010001;
    return t.wdata;
  endfunction

  function automatic logic [31:0] m_rd(txn_t t);
    int a = int'(t.addr[1:0]);
    logic [31:0] v;
    if (!t.is_data || t.size == 2'd2) return t.rdata;
    if (t.size == 2'd0) begin
      v = (t.rdata >> (8 * a)) & 32'hFF;
      if (t.sgn && v >= 32'd128) v = v + 32'hFFFFFF00;
    end else begin
      v = (t.rdata >> (16 * (a / 2))) & 32'hFFFF;
      if (t.sgn && v >= 32'd32768) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic int m_lat(txn_t t);
    if (m_mis(t)) return 1;
    return (t.we ? 2 : 3) + t.waits;
  endfunction

  // Raises the enabled requests together, serves the bus, and checks every transaction.
  task automatic run(input txn_t dt, input bit d_en, input txn_t ft, input bit f_en);
    txn_t q[$];
    txn_t cur;
    int start_edge = 0;
    int hc = 0;
    bit rd_next = 0;
    if (d_en && (DATA_FIRST || !f_en)) begin
      q.push_back(dt);
      if (f_en) q.push_back(ft);
    end else begin
      if (f_en) q.push_back(ft);
      if (d_en) q.push_back(dt);
    end
    @(posedge clk); #1;
    d_req = d_en; d_we = dt.we; d_size = dt.size; d_signed = dt.sgn;
    d_addr = dt.addr; d_wdata = dt.wdata;
    if_req = f_en; if_addr = ft.addr;
    for (int k = 0; k < 60 && q.size() > 0; k++) begin
      @(posedge clk); #1;
      cur = q[0];
      readdata = rd_next ? cur.rdata : $urandom;
      rd_next = 0;
      if (read && write) check("rw_exclusive", 32'd1, 32'd0);
      if (read || write) begin
        hc++;
        if (m_mis(cur)) check("bus_on_misaligned", 32'd1, 32'd0);
        check("address", address, {cur.addr[31:2], 2'b00});
        check("byteenable", {28'd0, byteenable}, {28'd0, m_be(cur)});
        check("direction", {31'd0, write}, {31'd0, cur.we});
        if (cur.we) check("writedata", writedata, m_wd(cur));
        waitrequest = (hc <= cur.waits);
        if (!waitrequest) begin
          check("hold_cycles", hc, cur.waits + 1);
          rd_next = !cur.we;
        end
      end else begin
        waitrequest = 1'b0;
      end
      if (if_ack || d_ack) begin
        check("ack_both", {31'd0, if_ack && d_ack}, 32'd0);
        check("ack_owner", {31'd0, d_ack}, {31'd0, cur.is_data});
        check("ack_edge", k + 1, start_edge + m_lat(cur));
        check("d_err", {31'd0, d_err}, {31'd0, m_mis(cur)});
        if (!cur.we && !m_mis(cur))
          check("rdata", cur.is_data ? d_rdata : if_rdata, m_rd(cur));
        if (!m_mis(cur)) exp_stall += cur.waits;
        check("stall_cnt", {16'd0, stall_cnt}, exp_stall);
        if (cur.is_data) d_req = 1'b0; else if_req = 1'b0;
        void'(q.pop_front());
        start_edge = k + 2;
        hc = 0;
      end
    end
    if (q.size() != 0) check("ack_timeout", q.size(), 0);
    if_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
  endtask

  task automatic reset_mid_bus();
    int seen = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h0000_4000; waitrequest = 1'b1;
    for (int k = 0; k < 10 && !read; k++) begin
      @(posedge clk); #1;
    end
    check("rst_read_started", {31'd0, read}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_read_drop", {31'd0, read}, 32'd0);
    check("rst_stall_clear", {16'd0, stall_cnt}, 32'd0);
    check("rst_address", address, 32'd0);
    reset = 1'b0; if_req = 1'b0; waitrequest = 1'b0;
    exp_stall = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (if_ack || d_ack || read || write) seen++;
    end
    check("rst_no_ack", seen, 0);
  endtask

  txn_t none, t, f;

  initial begin
    none = mk(0, 0, 2'd2, 0, 32'd0, 32'd0, 32'd0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_read", {31'd0, read}, 32'd0);
    check("reset_write", {31'd0, write}, 32'd0);
    check("reset_acks", {29'd0, if_ack, d_ack, d_err}, 32'd0);
    check("reset_be", {28'd0, byteenable}, 32'd0);
    check("reset_rdata", if_rdata | d_rdata | address | writedata, 32'd0);
    check("reset_stall", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;

    run(none, 0, mk(0, 0, 2'd2, 0, RESET_VECTOR, 32'd0, 32'h24020005, 0), 1);
    run(mk(1, 0, 2'd2, 0, 32'h1000, 32'd0, 32'h11223344, 0), 1,
        mk(0, 0, 2'd2, 0, RESET_VECTOR + 4, 32'd0, 32'h8C010000, 0), 1);
    run(mk(1, 1, 2'd2, 0, 32'h2004, 32'hDEADBEEF, 32'd0, 3), 1, none, 0);
    check("stall_three", {16'd0, stall_cnt}, 32'd3);
    run(mk(1, 0, 2'd0, 1, 32'h3003, 32'd0, 32'h80FF1234, 0), 1, none, 0);
    run(mk(1, 0, 2'd0, 0, 32'h3003, 32'd0, 32'h80FF1234, 0), 1, none, 0);
    run(mk(1, 1, 2'd1, 0, 32'h3002, 32'h0000ABCD, 32'd0, 0), 1, none, 0);
    run(mk(1, 0, 2'd2, 0, 32'h3001, 32'd0, 32'd0, 0), 1, none, 0);
    run(mk(1, 0, 2'd1, 1, 32'h3002, 32'd0, 32'h9ABC0000, 1), 1, none, 0);
    reset_mid_bus();

    for (int i = 0; i < 60; i++) begin
      t = mk(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(0, 3));
      f = mk(0, 0, 2'd2, 0, $urandom, 32'd0, $urandom, $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       run(t, 1, none, 0);
        1:       run(none, 0, f, 1);
        default: run(t, 1, f, 1);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Owns the single Avalon memory-mapped master port of the MIPS I CPU.
- Shares that port between two requesters: the instruction-fetch path and the load/store data path.
- Sequences each transfer through the waitrequest handshake, generates byteenable and lane-aligned writedata for byte/half/word accesses, and returns extended read data.
- Sits between the CPU state machine (FETCH/EXEC1/EXEC2) and the bus pins.

Parameters:
- DATA_FIRST, 1, when both requesters are pending in IDLE: 1 = data wins, 0 = fetch wins.
- PERF_W, 16, width of the saturating waitrequest stall counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held high until if_ack
- if_addr  input  32  fetch byte address; must be word aligned
- if_ack  output  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  output  32  fetched instruction word
- d_req  input  1  data request; held high until d_ack
- d_we  input  1  1 = store, 0 = load
- d_size  input  2  0 = byte, 1 = half, 2 = word; 3 is reserved and treated as misaligned
- d_signed  input  1  load sign-extends when 1 (LB/LH), zero-extends when 0
- d_addr  input  32  data byte address
- d_wdata  input  32  store data, right-justified
- d_ack  output  1  one-cycle completion pulse
- d_rdata  output  32  extended load result; valid with d_ack
- d_err  output  1  pulses with d_ack on a misaligned access
- stall_cnt  output  PERF_W  count of cycles with read|write high and waitrequest high; saturates
- address  output  32  Avalon address, always word aligned
- read  output  1  Avalon read
- write  output  1  Avalon write
- waitrequest  input  1  Avalon waitrequest
- writedata  output  32  Avalon write data
- byteenable  output  4  Avalon byte enables
- readdata  input  32  Avalon read data

Behaviour:
- Reset (synchronous) sets: state=IDLE; read, write, if_ack, d_ack, d_err = 0; address, writedata, if_rdata, d_rdata = 0; byteenable = 0; stall_cnt = 0.
- A reset asserted mid-transaction drops that transaction at the same edge. No ack is issued for it.
- State IDLE:
  - Sample requests and select one, applying DATA_FIRST when both are pending.
  - Misaligned data access: half with d_addr[0]=1, word with d_addr[1:0]!=0, or d_size=3. Go to DONE with d_err=1. No bus cycle is issued.
  - Otherwise register address={addr[31:2],2'b00}, byteenable, writedata and read/write, then go to BUS.
- State BUS:
  - read or write is held high and address, byteenable and writedata are held stable while waitrequest=1.
  - On the first cycle with waitrequest=0 the transfer is accepted and read/write drop at the next edge.
  - Write accepted: go to DONE.
  - Read accepted: go to RDATA.
- State RDATA:
  - readdata is valid in the cycle after acceptance (fixed latency 1). Capture and extend it.
  - Go to DONE.
- State DONE:
  - Pulse exactly one of if_ack or d_ack for one cycle, then return to IDLE.
  - No new bus request is issued in this cycle. Minimum turnaround is one idle bus cycle.
- Latency with waitrequest=0 throughout:
  - Read: req sampled at edge 0; ack at edge 3.
  - Write: ack at edge 2.
  - Misaligned: ack at edge 1.
- Byte lanes (little-endian):
  - byte: byteenable = 4'b0001 << addr[1:0]; writedata = {4{wdata[7:0]}}.
  - half: byteenable = addr[1] ? 4'b1100 : 4'b0011; writedata = {2{wdata[15:0]}}.
  - word: byteenable = 4'b1111.
- Load extraction:
  - byte: lane = readdata >> (8*addr[1:0]).
  - half: lane = readdata >> (16*addr[1]).
  - Sign-extend or zero-extend from bit 7 or bit 15 per d_signed. Word loads are passed through.
  - Fetch always reads a word, byteenable=4'b1111. if_addr[1:0] is ignored.
- Request inputs are only sampled in IDLE. Changes while busy are ignored until the next IDLE.
- The CPU issues at most one data request per instruction, so fetch cannot be starved under DATA_FIRST=1.
- Only one transaction is outstanding at any time. read and write are never high together.

Decomposition:
- Shared package mips_pkg:
  - bus_state_t enum: IDLE, BUS, RDATA, DONE.
  - access_size_t: SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
  - Constant RESET_VECTOR = 32'hBFC00000, used by the CPU and the benches.
- Sub-module mips_bus_lane (combinational):
  - Store path: takes size, addr[1:0] and wdata; produces byteenable and writedata.
  - Load path: takes size, signed, addr[1:0] and readdata; produces extended rdata.
  - The arbiter FSM instantiates it once.

Test Plan:
- Fetch only: if_req, if_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 → address=0xBFC00000, read high 1 cycle, byteenable=4'hF, if_ack at edge 3 with if_rdata=0x24020005.
- Simultaneous requests: if_req and d_req (LW 0x1000) in the same cycle, DATA_FIRST=1 → data transaction first, d_ack; fetch is issued on the following IDLE.
- Stall handling: SW 0x2004 with d_wdata=0xDEADBEEF and waitrequest high for 3 cycles → write held with constant address and writedata for 4 cycles; d_ack once; stall_cnt=3.
- Byte load: LB from 0x3003 with readdata=0x80FF1234, d_signed=1 → d_rdata=0xFFFFFF80; with d_signed=0 → 0x00000080.
- Half store: SH to 0x3002 with d_wdata=0x0000ABCD → byteenable=4'b1100, writedata=0xABCDABCD.
- Misaligned access and reset: LW from 0x3001 → d_ack with d_err=1 at edge 1 and no read asserted. Reset asserted during BUS with waitrequest=1 → read=0 at the next edge and no ack.
